// File: rtl/bus_mem_responder.sv
// Single-port word memory behind the bus_sys read/write responder channels.
// Serialises reads and writes, alternates grants on ties and models fixed access latency.
module bus_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              ctrl_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_iData,
  input  logic              write,
  output logic              write_waitrequest,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              read,
  output logic [DATA_W-1:0] read_oData,
  output logic              read_waitrequest,
  output logic              addr_err
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_BUSY = 3'd1;
  localparam logic [2:0] WR_BUSY = 3'd2;
  localparam logic [2:0] RD_DONE = 3'd3;
  localparam logic [2:0] WR_DONE = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_wr;
  logic [MEM_AW-1:0] lat_midx;
  logic              lat_oor;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_wr, acc_rd;
  logic [IDX_W-1:0]  req_idx;
  logic              cur_oor;
  logic [MEM_AW-1:0] cur_midx;
  logic [DATA_W-1:0] cur_data;
  logic              mem_we;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^{write_addr[1:0], read_addr[1:0]};

  // On a tie the channel that did not win the previous tie gets the grant.
  assign acc_wr  = (state == IDLE) && write && (!read || !last_wr);
  assign acc_rd  = (state == IDLE) && read && !acc_wr;
  assign req_idx = acc_wr ? write_addr[ADDR_W-1:2] : read_addr[ADDR_W-1:2];

  // Live request fields while accepting (LAT=1 goes straight to DONE), latched ones otherwise.
  assign cur_oor  = (state == IDLE) ? (req_idx >= DEPTH_IDX) : lat_oor;
  assign cur_midx = (state == IDLE) ? req_idx[MEM_AW-1:0] : lat_midx;
  assign cur_data = (state == IDLE) ? write_iData : lat_data;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_wr)      state_nxt = (WR_LAT == 1) ? WR_DONE : WR_BUSY;
        else if (acc_rd) state_nxt = (RD_LAT == 1) ? RD_DONE : RD_BUSY;
      end
      RD_BUSY: if (cnt == CNT_W'(1)) state_nxt = RD_DONE;
      WR_BUSY: if (cnt == CNT_W'(1)) state_nxt = WR_DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_we = (state_nxt == WR_DONE) && !cur_oor;

  // Memory is not reset; a write pending when reset hits is never committed.
  always_ff @(posedge ctrl_clk) begin
    if (mem_we && reset_n) mem[cur_midx] <= cur_data;
  end

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      last_wr           <= 1'b0;
      lat_midx          <= '0;
      lat_oor           <= 1'b0;
      lat_data          <= '0;
      write_waitrequest <= 1'b1;
      read_waitrequest  <= 1'b1;
      read_oData        <= '0;
      addr_err          <= 1'b0;
    end else begin
      state             <= state_nxt;
      write_waitrequest <= (state_nxt != WR_DONE);
      read_waitrequest  <= (state_nxt != RD_DONE);
      addr_err          <= ((state_nxt == WR_DONE) || (state_nxt == RD_DONE)) && cur_oor;
      if (state_nxt == RD_DONE) read_oData <= cur_oor ? '0 : mem[cur_midx];
      if (acc_wr || acc_rd) begin
        lat_midx <= cur_midx;
        lat_oor  <= cur_oor;
        lat_data <= write_iData;
        cnt      <= acc_wr ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
        if (read && write) last_wr <= acc_wr;
      end else if ((state == RD_BUSY) || (state == WR_BUSY)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule
